// File: rtl/ipl_iack_responder.sv
// CPU-side interrupt level qualifier and IACK autovector responder.
// Qualifies the encoded IPL lines and answers acknowledge cycles.
module ipl_iack_responder #(
    parameter int unsigned IACK_WAIT = 2,
    parameter bit          AUTO_ACK  = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_EN,
    input  logic       IPL0,
    input  logic       IPL1,
    input  logic [2:0] IMASK,
    input  logic       IACK_REQ,
    input  logic [2:0] IACK_LEVEL,
    output logic       INT_PENDING,
    output logic [2:0] INT_LEVEL,
    output logic       IACK_DONE,
    output logic [7:0] VECTOR,
    output logic       SPURIOUS,
    output logic       WR_ACK,
    output logic [2:0] ACK_BITS
);

    localparam logic [3:0] WAIT_INIT = 4'(IACK_WAIT);
    localparam logic [7:0] AUTOVEC   = 8'h18;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP,
        S_HOLD
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] raw;
    logic [2:0] s1;
    logic [2:0] lvl;
    logic [3:0] cnt;
    logic       go;
    logic       valid;
    logic       done_d;
    logic       spur_d;
    logic       wr_d;
    logic [2:0] bits_d;
    logic [7:0] vector_d;

    // IPL2 is tied inactive, so only levels 0..3 can be encoded.
    assign raw = ~{1'b1, IPL1, IPL0};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (IACK_REQ) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!IACK_REQ) begin
                    state_nxt = S_IDLE;
                end else if (CLK_EN && cnt == 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!IACK_REQ) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign go    = (state == S_WAIT) && (state_nxt == S_RESP);
    assign valid = (lvl == INT_LEVEL) && (lvl != 3'd0);

    always_comb begin
        done_d   = 1'b0;
        spur_d   = 1'b0;
        wr_d     = 1'b0;
        bits_d   = 3'b000;
        vector_d = VECTOR;
        if (go) begin
            done_d = 1'b1;
            if (valid) begin
                vector_d = AUTOVEC + {5'd0, lvl};
                if (AUTO_ACK) begin
                    wr_d = 1'b1;
                    unique case (lvl)
                        3'd3:    bits_d = 3'b001;
                        3'd2:    bits_d = 3'b010;
                        3'd1:    bits_d = 3'b100;
                        default: bits_d = 3'b000;
                    endcase
                end
            end else begin
                vector_d = AUTOVEC;
                spur_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1          <= 3'd0;
            INT_LEVEL   <= 3'd0;
            INT_PENDING <= 1'b0;
            lvl         <= 3'd0;
            cnt         <= 4'd0;
            IACK_DONE   <= 1'b0;
            SPURIOUS    <= 1'b0;
            WR_ACK      <= 1'b0;
            ACK_BITS    <= 3'b000;
            VECTOR      <= 8'd0;
        end else begin
            INT_PENDING <= (INT_LEVEL > IMASK);
            if (CLK_EN) begin
                s1 <= raw;
                // Two equal consecutive samples filter single-tick glitches.
                if (s1 == raw) begin
                    INT_LEVEL <= raw;
                end
            end
            if (state == S_IDLE && IACK_REQ) begin
                lvl <= IACK_LEVEL;
                cnt <= WAIT_INIT;
            end else if (state == S_WAIT && CLK_EN) begin
                cnt <= cnt - 4'd1;
            end
            IACK_DONE <= done_d;
            SPURIOUS  <= spur_d;
            WR_ACK    <= wr_d;
            ACK_BITS  <= bits_d;
            VECTOR    <= vector_d;
        end
    end

endmodule

// File: tb/tb_ipl_iack_responder.sv
// Directed bench for ipl_iack_responder: level qualification,
// autovector responses, spurious cases, reset abort and AUTO_ACK=0.
module tb_ipl_iack_responder;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CLK_EN = 1'b0;
    logic       IPL0 = 1'b1;
    logic       IPL1 = 1'b1;
    logic [2:0] IMASK = 3'd0;
    logic       IACK_REQ = 1'b0;
    logic [2:0] IACK_LEVEL = 3'd0;

    logic       pend_a, pend_n, pend_w;
    logic [2:0] lev_a, lev_n, lev_w;
    logic       done_a, done_n, done_w;
    logic [7:0] vec_a, vec_n, vec_w;
    logic       spur_a, spur_n, spur_w;
    logic       wr_a, wr_n, wr_w;
    logic [2:0] bits_a, bits_n, bits_w;

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    ipl_iack_responder #(.IACK_WAIT(2), .AUTO_ACK(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN),
        .IPL0(IPL0), .IPL1(IPL1), .IMASK(IMASK),
        .IACK_REQ(IACK_REQ), .IACK_LEVEL(IACK_LEVEL),
        .INT_PENDING(pend_a), .INT_LEVEL(lev_a),
        .IACK_DONE(done_a), .VECTOR(vec_a), .SPURIOUS(spur_a),
        .WR_ACK(wr_a), .ACK_BITS(bits_a)
    );

    ipl_iack_responder #(.IACK_WAIT(2), .AUTO_ACK(1'b0)) dut_na (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN),
        .IPL0(IPL0), .IPL1(IPL1), .IMASK(IMASK),
        .IACK_REQ(IACK_REQ), .IACK_LEVEL(IACK_LEVEL),
        .INT_PENDING(pend_n), .INT_LEVEL(lev_n),
        .IACK_DONE(done_n), .VECTOR(vec_n), .SPURIOUS(spur_n),
        .WR_ACK(wr_n), .ACK_BITS(bits_n)
    );

    ipl_iack_responder #(.IACK_WAIT(1), .AUTO_ACK(1'b1)) dut_w1 (
        .CLK(CLK), .RESET(RESET), .CLK_EN(CLK_EN),
        .IPL0(IPL0), .IPL1(IPL1), .IMASK(IMASK),
        .IACK_REQ(IACK_REQ), .IACK_LEVEL(IACK_LEVEL),
        .INT_PENDING(pend_w), .INT_LEVEL(lev_w),
        .IACK_DONE(done_w), .VECTOR(vec_w), .SPURIOUS(spur_w),
        .WR_ACK(wr_w), .ACK_BITS(bits_w)
    );

    task automatic cyc(input logic en);
        CLK_EN = en;
        @(posedge CLK);
        #1;
        CLK_EN = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset then idle
        cyc(1'b0);
        cyc(1'b0);
        RESET = 1'b0;
        cyc(1'b0);
        chk("rst_level", {5'd0, lev_a}, 8'd0);
        chk("rst_pend", {7'd0, pend_a}, 8'd0);
        chk("rst_done", {7'd0, done_a}, 8'd0);
        chk("rst_wr", {7'd0, wr_a}, 8'd0);
        chk("rst_bits", {5'd0, bits_a}, 8'd0);
        chk("rst_vec", vec_a, 8'd0);
        chk("rst_spur", {7'd0, spur_a}, 8'd0);

        // 2: level 1 qualifies after two samples, pending one CLK later
        IPL1 = 1'b1; IPL0 = 1'b0; IMASK = 3'd0;
        cyc(1'b1);
        chk("qual_1st", {5'd0, lev_a}, 8'd0);
        cyc(1'b1);
        chk("qual_2nd", {5'd0, lev_a}, 8'd1);
        chk("pend_lag", {7'd0, pend_a}, 8'd0);
        cyc(1'b0);
        chk("pend_on", {7'd0, pend_a}, 8'd1);
        IMASK = 3'd1;
        cyc(1'b0);
        chk("pend_mask", {7'd0, pend_a}, 8'd0);

        // 3: single-sample glitch to level 3 is filtered
        IPL1 = 1'b1; IPL0 = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        chk("back_0", {5'd0, lev_a}, 8'd0);
        IMASK = 3'd0;
        IPL1 = 1'b0; IPL0 = 1'b0;
        cyc(1'b1);
        IPL1 = 1'b1; IPL0 = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        chk("glitch_lvl", {5'd0, lev_a}, 8'd0);
        chk("glitch_pend", {7'd0, pend_a}, 8'd0);

        // 4: valid level-2 acknowledge with auto-ack
        IPL1 = 1'b0; IPL0 = 1'b1;
        cyc(1'b1);
        cyc(1'b1);
        chk("lvl2", {5'd0, lev_a}, 8'd2);
        IACK_REQ = 1'b1; IACK_LEVEL = 3'd2;
        cyc(1'b0);
        chk("acc_done", {7'd0, done_a}, 8'd0);
        cyc(1'b1);
        chk("w1_done", {7'd0, done_w}, 8'd1);
        chk("w1_vec", vec_w, 8'h1A);
        chk("wait_done", {7'd0, done_a}, 8'd0);
        cyc(1'b1);
        chk("v2_done", {7'd0, done_a}, 8'd1);
        chk("v2_vec", vec_a, 8'h1A);
        chk("v2_spur", {7'd0, spur_a}, 8'd0);
        chk("v2_wr", {7'd0, wr_a}, 8'd1);
        chk("v2_bits", {5'd0, bits_a}, 8'h02);
        chk("v2_na_wr", {7'd0, wr_n}, 8'd0);
        cyc(1'b0);
        chk("v2_strobe", {7'd0, done_a}, 8'd0);
        chk("v2_wr_off", {7'd0, wr_a}, 8'd0);
        chk("v2_bits_off", {5'd0, bits_a}, 8'd0);
        chk("v2_vec_hold", vec_a, 8'h1A);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1);
            chk("hold_nodone", {7'd0, done_a}, 8'd0);
        end
        IACK_REQ = 1'b0;
        cyc(1'b0);

        // 5: level 1 drops during WAIT -> spurious
        IPL1 = 1'b1; IPL0 = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("lvl1", {5'd0, lev_a}, 8'd1);
        IPL1 = 1'b1; IPL0 = 1'b1;
        cyc(1'b1);
        chk("lvl1_kept", {5'd0, lev_a}, 8'd1);
        IACK_REQ = 1'b1; IACK_LEVEL = 3'd1;
        cyc(1'b0);
        cyc(1'b1);
        chk("lvl_drop", {5'd0, lev_a}, 8'd0);
        cyc(1'b1);
        chk("sp_done", {7'd0, done_a}, 8'd1);
        chk("sp_vec", vec_a, 8'h18);
        chk("sp_spur", {7'd0, spur_a}, 8'd1);
        chk("sp_wr", {7'd0, wr_a}, 8'd0);
        chk("sp_bits", {5'd0, bits_a}, 8'd0);
        cyc(1'b0);
        chk("sp_spur_off", {7'd0, spur_a}, 8'd0);
        IACK_REQ = 1'b0;
        cyc(1'b0);

        // 6: reset during WAIT aborts silently
        IPL1 = 1'b0; IPL0 = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("lvl3", {5'd0, lev_a}, 8'd3);
        IACK_REQ = 1'b1; IACK_LEVEL = 3'd3;
        cyc(1'b0);
        cyc(1'b1);
        RESET = 1'b1;
        IACK_REQ = 1'b0;
        cyc(1'b1);
        RESET = 1'b0;
        chk("rw_done", {7'd0, done_a}, 8'd0);
        chk("rw_wr", {7'd0, wr_a}, 8'd0);
        chk("rw_lvl", {5'd0, lev_a}, 8'd0);
        cyc(1'b1);
        chk("rw_done2", {7'd0, done_a}, 8'd0);
        chk("rw_wr2", {7'd0, wr_a}, 8'd0);
        cyc(1'b1);
        chk("rw_requal", {5'd0, lev_a}, 8'd3);

        // Reset wins over a simultaneous request
        RESET = 1'b1; IACK_REQ = 1'b1;
        cyc(1'b1);
        RESET = 1'b0; IACK_REQ = 1'b0;
        cyc(1'b1);
        cyc(1'b1);
        chk("rr_done", {7'd0, done_a}, 8'd0);
        cyc(1'b1);
        chk("rr_requal", {5'd0, lev_a}, 8'd3);

        // Level-3 acknowledge, CLK_EN stalled, IACK_LEVEL changed late
        IACK_REQ = 1'b1; IACK_LEVEL = 3'd3;
        cyc(1'b0);
        IACK_LEVEL = 3'd1;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0);
            chk("stall_done", {7'd0, done_a}, 8'd0);
        end
        cyc(1'b1);
        chk("l3_pre", {7'd0, done_a}, 8'd0);
        cyc(1'b1);
        chk("l3_done", {7'd0, done_a}, 8'd1);
        chk("l3_vec", vec_a, 8'h1B);
        chk("l3_wr", {7'd0, wr_a}, 8'd1);
        chk("l3_bits", {5'd0, bits_a}, 8'h01);
        chk("na_done", {7'd0, done_n}, 8'd1);
        chk("na_vec", vec_n, 8'h1B);
        chk("na_spur", {7'd0, spur_n}, 8'd0);
        chk("na_wr", {7'd0, wr_n}, 8'd0);
        chk("na_bits", {5'd0, bits_n}, 8'd0);
        IACK_REQ = 1'b0;
        cyc(1'b0);
        cyc(1'b0);
        chk("end_done", {7'd0, done_a}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
